// File: rtl/dds_pkg.sv
`default_nettype none
// dds_pkg: sweep mode codes and controller state encoding shared by the sweep controller files.
package dds_pkg;

  localparam logic [1:0] SWP_SINGLE = 2'b00;
  localparam logic [1:0] SWP_REPEAT = 2'b01;
  localparam logic [1:0] SWP_BIDIR  = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

endpackage
`default_nettype wire

// File: rtl/dds_dwell_timer.sv
`default_nettype none
// dds_dwell_timer: down-counter that pulses expire_o when a dwell period ends.
// The counter reloads itself on expiry, so each dwell lasts reload_i+1 cycles.
module dds_dwell_timer #(
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   run_i,
  input  logic [DWELL_WIDTH-1:0] reload_i,
  output logic                   expire_o
);

  logic [DWELL_WIDTH-1:0] cnt_q;
  logic [DWELL_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = reload_i;
    end else if (run_i) begin
      cnt_d = (cnt_q == '0) ? reload_i : cnt_q - DWELL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = run_i && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// dds_sweep_ctrl: frequency-sweep controller driving the DDS fre/pha words (single/repeat/bidir).
// Optional define DDS_SWEEP_MARKER_EN adds cfg_marker_i and a marker_o crossing pulse.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int PHASE_WIDTH = 32,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [PHASE_WIDTH-1:0] cfg_start_i,
  input  logic [PHASE_WIDTH-1:0] cfg_stop_i,
  input  logic [PHASE_WIDTH-1:0] cfg_step_i,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell_i,
  input  logic [1:0]             cfg_mode_i,
  input  logic [PHASE_WIDTH-1:0] cfg_pha_i,
`ifdef DDS_SWEEP_MARKER_EN
  input  logic [PHASE_WIDTH-1:0] cfg_marker_i,
  output logic                   marker_o,
`endif
  input  logic                   start_i,
  input  logic                   abort_i,
  output logic [PHASE_WIDTH-1:0] fre_word_o,
  output logic [PHASE_WIDTH-1:0] pha_word_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   wrap_o
);

  sweep_state_e           state_q;
  logic [PHASE_WIDTH-1:0] start_q, stop_q, step_q, pha_cfg_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [1:0]             mode_q;
  logic [PHASE_WIDTH-1:0] fre_q, fre_d, pha_q, pha_d;
  logic                   up_q, up_d, to_stop_q, to_stop_d;
  logic                   done_q, wrap_q;

  logic                   w_cfg_accept, w_expire, w_at_target;
  logic                   w_launch, w_finish, w_wrap;
  logic [PHASE_WIDTH-1:0] w_target, w_rev_target;
  logic [DWELL_WIDTH-1:0] w_reload;

  // Carry/borrow in the extra bit forces a clamp, so the word never wraps past the target.
  function automatic logic [PHASE_WIDTH-1:0] step_toward(
    input logic [PHASE_WIDTH-1:0] cur,
    input logic [PHASE_WIDTH-1:0] step,
    input logic [PHASE_WIDTH-1:0] target,
    input logic                   up
  );
    logic [PHASE_WIDTH:0] nxt;
    logic                 clamp;
    if (up) begin
      nxt   = {1'b0, cur} + {1'b0, step};
      clamp = nxt[PHASE_WIDTH] || (nxt[PHASE_WIDTH-1:0] >= target);
    end else begin
      nxt   = {1'b0, cur} - {1'b0, step};
      clamp = nxt[PHASE_WIDTH] || (nxt[PHASE_WIDTH-1:0] <= target);
    end
    step_toward = clamp ? target : nxt[PHASE_WIDTH-1:0];
  endfunction

  assign w_cfg_accept = cfg_valid_i && (state_q == ST_IDLE);
  assign w_target     = to_stop_q ? stop_q : start_q;
  assign w_rev_target = to_stop_q ? start_q : stop_q;
  assign w_at_target  = (fre_q == w_target);
  assign w_reload     = (dwell_q == '0) ? '0 : dwell_q - DWELL_WIDTH'(1);

  dds_dwell_timer #(
    .DWELL_WIDTH(DWELL_WIDTH)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (w_launch),
    .run_i    (state_q == ST_SWEEP),
    .reload_i (w_reload),
    .expire_o (w_expire)
  );

  always_comb begin
    fre_d     = fre_q;
    pha_d     = pha_q;
    up_d      = up_q;
    to_stop_d = to_stop_q;
    w_launch  = 1'b0;
    w_finish  = 1'b0;
    w_wrap    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start_i && !abort_i) begin
        w_launch  = 1'b1;
        fre_d     = start_q;
        pha_d     = pha_cfg_q;
        up_d      = (stop_q >= start_q);
        to_stop_d = 1'b1;
      end
    end else if (!abort_i && w_expire) begin
      if (!w_at_target) begin
        fre_d = step_toward(fre_q, step_q, w_target, up_q);
      end else begin
        case (mode_q)
          SWP_REPEAT: begin
            fre_d  = start_q;
            w_wrap = 1'b1;
          end
          SWP_BIDIR: begin
            fre_d     = step_toward(fre_q, step_q, w_rev_target, !up_q);
            up_d      = !up_q;
            to_stop_d = !to_stop_q;
            w_wrap    = 1'b1;
          end
          default: w_finish = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      mode_q    <= SWP_SINGLE;
      pha_cfg_q <= '0;
      fre_q     <= '0;
      pha_q     <= '0;
      up_q      <= 1'b0;
      to_stop_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      if (w_cfg_accept) begin
        start_q   <= cfg_start_i;
        stop_q    <= cfg_stop_i;
        step_q    <= cfg_step_i;
        dwell_q   <= cfg_dwell_i;
        mode_q    <= cfg_mode_i;
        pha_cfg_q <= cfg_pha_i;
      end
      fre_q     <= fre_d;
      pha_q     <= pha_d;
      up_q      <= up_d;
      to_stop_q <= to_stop_d;
      done_q    <= w_finish;
      wrap_q    <= w_wrap;
      case (state_q)
        ST_IDLE:  if (w_launch) state_q <= ST_SWEEP;
        ST_SWEEP: if (abort_i || w_finish) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DDS_SWEEP_MARKER_EN
  logic [PHASE_WIDTH-1:0] marker_cfg_q;
  logic                   marked_q, marker_q, w_hit;

  assign w_hit = up_d ? (fre_d >= marker_cfg_q) : (fre_d <= marker_cfg_q);

  // A pass restarts at launch and at every reload/reversal; the pulse fires once per pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      marker_cfg_q <= '0;
      marked_q     <= 1'b0;
      marker_q     <= 1'b0;
    end else begin
      if (w_cfg_accept) marker_cfg_q <= cfg_marker_i;
      marker_q <= 1'b0;
      if (w_launch || w_wrap) begin
        marked_q <= w_hit;
        marker_q <= w_hit;
      end else if ((state_q == ST_SWEEP) && !abort_i && w_expire && w_hit && !marked_q) begin
        marked_q <= 1'b1;
        marker_q <= 1'b1;
      end
    end
  end

  assign marker_o = marker_q;
`endif

  assign cfg_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q == ST_SWEEP);
  assign fre_word_o  = fre_q;
  assign pha_word_o  = pha_q;
  assign done_o      = done_q;
  assign wrap_o      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// Bench for dds_sweep_ctrl: vector table, reset/abort/config corner sequences, and random
// sweeps compared cycle by cycle against a trace built from the sweep rules.
module tb_dds_sweep_ctrl;

  localparam int NCYC = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic [31:0] cfg_start_i = '0, cfg_stop_i = '0, cfg_step_i = '0, cfg_pha_i = '0;
  logic [23:0] cfg_dwell_i = '0;
  logic [1:0]  cfg_mode_i = '0;
  logic        start_i = 1'b0, abort_i = 1'b0;
  logic [31:0] fre_word_o, pha_word_o;
  logic        busy_o, done_o, wrap_o;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.PHASE_WIDTH(32), .DWELL_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i), .cfg_step_i(cfg_step_i),
    .cfg_dwell_i(cfg_dwell_i), .cfg_mode_i(cfg_mode_i), .cfg_pha_i(cfg_pha_i),
    .start_i(start_i), .abort_i(abort_i), .fre_word_o(fre_word_o), .pha_word_o(pha_word_o),
    .busy_o(busy_o), .done_o(done_o), .wrap_o(wrap_o)
  );

  typedef struct packed {
    logic [31:0] fre;
    logic        busy;
    logic        done;
    logic        wrap;
  } obs_t;

  typedef struct {
    logic [31:0] s, e, st;
    logic [23:0] dw;
    logic [1:0]  md;
    int          cyc;
    obs_t        exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  obs_t        exp_q[$];
  logic [31:0] pass_q[$];
  vec_t        vecs[$];

  function automatic obs_t observe();
    return {fre_word_o, busy_o, done_o, wrap_o};
  endfunction

  function automatic vec_t mk(input logic [31:0] s, e, st, input logic [23:0] dw,
                              input logic [1:0] md, input int cyc, input logic [31:0] fre,
                              input logic b, input logic d, input logic w);
    vec_t v;
    v.s = s; v.e = e; v.st = st; v.dw = dw; v.md = md; v.cyc = cyc;
    v.exp = {fre, b, d, w};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [31:0] s, e, st, input logic [23:0] dw,
                           input logic [1:0] md, input logic [31:0] ph);
    cfg_start_i = s; cfg_stop_i = e; cfg_step_i = st;
    cfg_dwell_i = dw; cfg_mode_i = md; cfg_pha_i = ph;
    cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
  endtask

  task automatic start_sweep();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic do_abort();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
  endtask

  // One pass of distinct values from 'from' toward 'to', clamped at 'to', in wide arithmetic.
  task automatic build_pass(input logic [31:0] from, input logic [31:0] to, input logic [31:0] stp);
    longint unsigned v, t, s;
    v = from; t = to; s = stp;
    pass_q.delete();
    pass_q.push_back(from);
    while (v != t && s != 0 && pass_q.size() < 100) begin
      if (t >= longint'(from)) v = (v + s > t) ? t : v + s;
      else                     v = (v <= t + s) ? t : v - s;
      pass_q.push_back(v[31:0]);
    end
  endtask

  task automatic build_trace(input logic [31:0] s, e, stp, input logic [23:0] dw, input logic [1:0] md);
    int d, seg;
    d = (dw == 0) ? 1 : int'(dw);
    exp_q.delete();
    if (stp == 0 && s != e) begin
      repeat (NCYC) exp_q.push_back({s, 1'b1, 1'b0, 1'b0});
    end else if (md == 2'd0 || md == 2'd3) begin
      build_pass(s, e, stp);
      foreach (pass_q[k]) repeat (d) exp_q.push_back({pass_q[k], 1'b1, 1'b0, 1'b0});
      exp_q.push_back({e, 1'b0, 1'b1, 1'b0});
      while (exp_q.size() < NCYC) exp_q.push_back({e, 1'b0, 1'b0, 1'b0});
    end else begin
      seg = 0;
      while (exp_q.size() < NCYC) begin
        if (md == 2'd1 || seg % 2 == 0) build_pass(s, e, stp);
        else                            build_pass(e, s, stp);
        if (md == 2'd2 && seg > 0 && s != e) void'(pass_q.pop_front());
        foreach (pass_q[k])
          for (int j = 0; j < d; j++)
            exp_q.push_back({pass_q[k], 1'b1, 1'b0, (seg > 0 && k == 0 && j == 0)});
        seg++;
      end
    end
  endtask

  initial begin
    vecs.push_back(mk(100, 130, 10, 3, 0, 1, 100, 1, 0, 0));
    vecs.push_back(mk(100, 130, 10, 3, 0, 3, 100, 1, 0, 0));
    vecs.push_back(mk(100, 130, 10, 3, 0, 4, 110, 1, 0, 0));
    vecs.push_back(mk(100, 130, 10, 3, 0, 12, 130, 1, 0, 0));
    vecs.push_back(mk(100, 130, 10, 3, 0, 13, 130, 0, 1, 0));
    vecs.push_back(mk(100, 130, 10, 3, 0, 14, 130, 0, 0, 0));
    vecs.push_back(mk(32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20, 1, 0, 1, 32'hFFFFFFF0, 1, 0, 0));
    vecs.push_back(mk(32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20, 1, 0, 2, 32'hFFFFFFFF, 1, 0, 0));
    vecs.push_back(mk(32'hFFFFFFF0, 32'hFFFFFFFF, 32'h20, 1, 0, 3, 32'hFFFFFFFF, 0, 1, 0));
    vecs.push_back(mk(50, 20, 15, 2, 2, 5, 20, 1, 0, 0));
    vecs.push_back(mk(50, 20, 15, 2, 2, 7, 35, 1, 0, 1));
    vecs.push_back(mk(50, 20, 15, 2, 2, 8, 35, 1, 0, 0));
    vecs.push_back(mk(50, 20, 15, 2, 2, 9, 50, 1, 0, 0));
    vecs.push_back(mk(50, 20, 15, 2, 2, 11, 35, 1, 0, 1));
    vecs.push_back(mk(0, 8, 4, 1, 1, 3, 8, 1, 0, 0));
    vecs.push_back(mk(0, 8, 4, 1, 1, 4, 0, 1, 0, 1));
    vecs.push_back(mk(0, 8, 4, 1, 1, 5, 4, 1, 0, 0));
    vecs.push_back(mk(10, 12, 1, 0, 0, 4, 12, 0, 1, 0));
    vecs.push_back(mk(5, 0, 7, 1, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk(5, 0, 7, 1, 0, 3, 0, 0, 1, 0));
    vecs.push_back(mk(1, 3, 2, 1, 3, 3, 3, 0, 1, 0));
    vecs.push_back(mk(7, 9, 0, 1, 0, 20, 7, 1, 0, 0));
    vecs.push_back(mk(4, 4, 1, 2, 0, 3, 4, 0, 1, 0));
    vecs.push_back(mk(4, 4, 1, 2, 1, 3, 4, 1, 0, 1));
    vecs.push_back(mk(4, 4, 1, 2, 1, 4, 4, 1, 0, 0));
    vecs.push_back(mk(4, 4, 1, 2, 2, 5, 4, 1, 0, 1));

    // Reset state, then a start on the all-zero shadow config
    repeat (2) tick();
    chk("reset_outs", 64'(observe()), 64'({32'd0, 1'b0, 1'b0, 1'b0}));
    chk("reset_ready", 64'({cfg_ready_o, pha_word_o}), 64'({1'b1, 32'd0}));
    rst_n = 1'b1;
    tick();
    start_sweep();
    chk("zero_cfg_c1", 64'(observe()), 64'({32'd0, 1'b1, 1'b0, 1'b0}));
    tick();
    chk("zero_cfg_c2", 64'(observe()), 64'({32'd0, 1'b0, 1'b1, 1'b0}));
    tick();

    foreach (vecs[i]) begin
      configure(vecs[i].s, vecs[i].e, vecs[i].st, vecs[i].dw, vecs[i].md, 32'h0);
      start_sweep();
      repeat (vecs[i].cyc - 1) tick();
      chk($sformatf("vec%0d_c%0d", i, vecs[i].cyc), 64'(observe()), 64'(vecs[i].exp));
      do_abort();
    end

    for (int it = 0; it < 20; it++) begin
      logic [31:0] s, e, st, delta, ph;
      logic [23:0] dw;
      logic [1:0]  md;
      case ($urandom_range(0, 2))
        0:       s = 32'hFFFFFFFF - 32'($urandom_range(0, 40));
        1:       s = 32'($urandom_range(0, 40));
        default: s = $urandom;
      endcase
      delta = 32'($urandom_range(0, 50));
      e  = ($urandom_range(0, 1) == 1) ? s + delta : s - delta;
      st = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(1, 20));
      dw = 24'($urandom_range(0, 3));
      md = 2'($urandom_range(0, 3));
      ph = $urandom;
      build_trace(s, e, st, dw, md);
      configure(s, e, st, dw, md, ph);
      start_sweep();
      chk($sformatf("rand%0d_pha", it), 64'(pha_word_o), 64'(ph));
      for (int c = 0; c < NCYC; c++) begin
        if (c > 0) tick();
        chk($sformatf("rand%0d_c%0d", it, c + 1), 64'(observe()), 64'(exp_q[c]));
      end
      do_abort();
      chk($sformatf("rand%0d_abort", it), 64'({cfg_ready_o, observe()}),
          64'({1'b1, exp_q[NCYC-1].fre, 1'b0, 1'b0, 1'b0}));
    end

    // Config offered while busy must be ignored
    configure(1000, 2000, 1, 5, 0, 32'hAA);
    start_sweep();
    chk("busy_ready", 64'(cfg_ready_o), 64'(0));
    cfg_start_i = 7; cfg_stop_i = 9; cfg_pha_i = 32'h55; cfg_valid_i = 1'b1;
    tick();
    cfg_valid_i = 1'b0;
    do_abort();
    chk("abort_idle", 64'({cfg_ready_o, busy_o}), 64'({1'b1, 1'b0}));
    start_sweep();
    chk("shadow_kept", 64'({fre_word_o, pha_word_o}), 64'({32'd1000, 32'hAA}));
    do_abort();

    // abort and start together in IDLE: abort wins
    start_i = 1'b1; abort_i = 1'b1;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    chk("abort_start", 64'(observe()), 64'({32'd1000, 1'b0, 1'b0, 1'b0}));
    tick();
    chk("abort_start_c2", 64'(busy_o), 64'(0));

    // Asynchronous reset in the middle of a sweep
    configure(100, 130, 10, 3, 0, 32'h1234);
    start_sweep();
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 64'({cfg_ready_o, observe(), pha_word_o}),
        64'({1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0}));
    repeat (3) tick();
    chk("rst_hold", 64'({cfg_ready_o, observe()}), 64'({1'b1, 32'd0, 1'b0, 1'b0, 1'b0}));
    rst_n = 1'b1;
    tick();
    configure(100, 130, 10, 3, 0, 32'h0);
    start_sweep();
    chk("post_rst_c1", 64'(observe()), 64'({32'd100, 1'b1, 1'b0, 1'b0}));
    do_abort();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
